// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types: request/response structs and the MLEN/MSIZE/AXI_BURST encodings.
package cbus_arbiter_pkg;

    // Burst length encoding: beats minus one.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    // Bytes per beat.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 64;

    typedef struct packed {
        logic                     valid;
        logic                     is_write;
        logic [CBUS_ADDR_W-1:0]   addr;
        msize_t                   size;
        mlen_t                    len;
        axi_burst_t               burst;
        logic [CBUS_DATA_W-1:0]   data;
        logic [CBUS_DATA_W/8-1:0] strobe;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Round-robin pick: first valid index after 'last', wrapping modulo NUM_REQ.
module rr_select #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      index,
    output logic               any
);

    // cand[k] is the (k+1)-th index after last in cyclic order.
    logic [IW-1:0] cand [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IW'((int'(last) + gi + 1) % NUM_REQ);
        end
    endgenerate

    // Scan from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                index = cand[k];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// cbus arbiter: round-robin grant of one requester per burst to the memory side.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  cbus_req_t  [NUM_REQ-1:0]  ireqs,
    output cbus_resp_t [NUM_REQ-1:0]  iresps,
    output cbus_req_t                 oreq,
    input  cbus_resp_t                oresp
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IW-1:0] rr_idx_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_reg, state_next;
    rr_idx_t     sel_reg, sel_next;
    rr_idx_t     last_reg, last_next;
    logic [3:0]  beat_cnt_reg, beat_cnt_next;

    logic [NUM_REQ-1:0] req_valid;
    rr_idx_t            pick_index;
    logic               pick_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_valid
            assign req_valid[gi] = ireqs[gi].valid;
        end
    endgenerate

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_select (
        .valid (req_valid),
        .last  (last_reg),
        .index (pick_index),
        .any   (pick_any)
    );

    // State registers; reset abandons any burst in flight and gives requester 0 the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            last_reg     <= rr_idx_t'(NUM_REQ - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            last_reg     <= last_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state and output mux: grant is held for the whole burst, released only on ready&last.
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        last_next     = last_reg;
        beat_cnt_next = beat_cnt_reg;
        oreq          = '0;
        iresps        = '0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    sel_next      = pick_index;
                    beat_cnt_next = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                oreq            = ireqs[sel_reg];
                iresps[sel_reg] = oresp;
                if (oresp.ready) begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                end
                if (oresp.ready && oresp.last) begin
                    last_next  = sel_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
